// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: command codes,
// FSM state encoding and a small helper used when decoding commands.
package hilo_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam int OP_W = 3;

    // MULT and DIV treat their operands as two's complement; the U variants do not.
    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Command/result bundle between the controller (master) and the
// multiply/divide unit (slave). The op field is kept as a raw code so that
// undefined encodings can reach the unit and be ignored there.
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_unit_div_radix2_core.sv
// Unsigned radix-2 restoring divider. A load captures dividend and divisor;
// each step then produces one quotient bit, MSB first, so WIDTH steps leave
// the final quotient and remainder in the registers.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;

    // Shift the next dividend bit into the partial remainder and try a subtract;
    // the top bit of the trial is the borrow that decides the quotient bit.
    always_comb begin
        w_shifted = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, r_div};
    end

    // The quotient register doubles as the dividend shift register: dividend bits
    // leave from the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            if (w_trial[WIDTH]) begin
                r_rem <= w_shifted[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end else begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the MIPS execute stage. Owns the HI/LO pair,
// runs multi-cycle MULT/MULTU/DIV/DIVU and single-edge MTHI/MTLO, and exposes
// busy so the hazard unit can stall the pipeline.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_unit_if.slave  bus
);

    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_mulSigned;
    logic [WIDTH-1:0]   r_mulA;
    logic [WIDTH-1:0]   r_mulB;
    logic               r_negQ;
    logic               r_negR;
    logic               r_divZero;

    logic               w_accept;
    logic               w_opSigned;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_divLoad;
    logic               w_divStep;
    logic [2*WIDTH-1:0] w_mulAExt;
    logic [2*WIDTH-1:0] w_mulBExt;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;

    // Command decode in IDLE; the divider only sees operand magnitudes, signs are
    // remembered separately and applied in FIX.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && bus.start && !bus.flush;
        w_opSigned = is_signed_op(bus.op);
        w_aNeg     = w_opSigned && bus.a[WIDTH-1];
        w_bNeg     = w_opSigned && bus.b[WIDTH-1];
        w_absA     = w_aNeg ? (~bus.a + 1'b1) : bus.a;
        w_absB     = w_bNeg ? (~bus.b + 1'b1) : bus.b;
        w_divLoad  = w_accept && ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
        w_divStep  = (r_state == ST_DIV) && !bus.flush;
    end

    // Full-width product: sign- or zero-extend to 2*WIDTH so one unsigned multiply
    // serves both MULT and MULTU (two's complement is exact modulo 2^(2*WIDTH)).
    always_comb begin
        w_mulAExt = {{WIDTH{r_mulSigned & r_mulA[WIDTH-1]}}, r_mulA};
        w_mulBExt = {{WIDTH{r_mulSigned & r_mulB[WIDTH-1]}}, r_mulB};
        w_product = w_mulAExt * w_mulBExt;
    end

    div_radix2_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_divLoad),
        .i_step      (w_divStep),
        .i_dividend  (w_absA),
        .i_divisor   (w_absB),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Truncating-division sign fix-up; MIN_INT / -1 wraps naturally to MIN_INT.
    always_comb begin
        w_quoFix = r_negQ ? (~w_quo + 1'b1) : w_quo;
        w_remFix = r_negR ? (~w_rem + 1'b1) : w_rem;
    end

    // Main FSM plus the HI/LO registers; flush overrides everything and neither
    // writes HI/LO nor pulses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_mulSigned <= 1'b0;
            r_mulA      <= '0;
            r_mulB      <= '0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_divZero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                OP_MTHI: r_hi <= bus.a;
                                OP_MTLO: r_lo <= bus.a;
                                OP_MULT, OP_MULTU: begin
                                    r_state     <= ST_MUL;
                                    r_cnt       <= MUL_CNT_INIT;
                                    r_mulSigned <= w_opSigned;
                                    r_mulA      <= bus.a;
                                    r_mulB      <= bus.b;
                                end
                                OP_DIV, OP_DIVU: begin
                                    r_state   <= ST_DIV;
                                    r_cnt     <= DIV_CNT_INIT;
                                    r_negQ    <= w_aNeg ^ w_bNeg;
                                    r_negR    <= w_aNeg;
                                    r_divZero <= (bus.b == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (r_cnt == '0) begin
                            r_hi    <= w_product[2*WIDTH-1:WIDTH];
                            r_lo    <= w_product[WIDTH-1:0];
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_DIV: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_FIX: begin
                        if (!r_divZero) begin
                            r_hi <= w_remFix;
                            r_lo <= w_quoFix;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus a randomized command stream
// checked against an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;

    hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_unit #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO after a command, straight from MIPS arithmetic
    task automatic modelOp(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin sp = sa * sb; expHi = sp[63:32]; expLo = sp[31:0]; end
            3'd1: begin up = ua * ub; expHi = up[63:32]; expLo = up[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                expLo = sq[31:0]; expHi = sr[31:0];
            end
            3'd3: if (b != 0) begin
                up = ua / ub; expLo = up[31:0];
                up = ua % ub; expHi = up[31:0];
            end
            3'd4: expHi = a;
            3'd5: expLo = a;
            default: ;
        endcase
    endtask

    function automatic int expBusy(input logic [2:0] op);
        if (op <= 3'd1) return MUL_LAT;
        if (op <= 3'd3) return WIDTH + 1;
        return 0;
    endfunction

    // Issue one command, scramble the operand buses after acceptance, then
    // follow it to completion and compare against the model
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        modelOp(op, a, b);
        if (op >= 3'd4) begin
            checkOutput("mt_busy", {63'd0, bus.busy}, 64'd0);
            checkOutput("mt_done", {63'd0, bus.done}, 64'd0);
            checkOutput("mt_hi", {32'd0, bus.hi}, {32'd0, expHi});
            checkOutput("mt_lo", {32'd0, bus.lo}, {32'd0, expLo});
        end else begin
            n = 0;
            while (bus.busy === 1'b1 && n < 100) begin
                n++;
                tick();
            end
            checkOutput("busy_len", 64'(n), 64'(expBusy(op)));
            checkOutput("done_pulse", {63'd0, bus.done}, 64'd1);
            checkOutput("res_hi", {32'd0, bus.hi}, {32'd0, expHi});
            checkOutput("res_lo", {32'd0, bus.lo}, {32'd0, expLo});
            tick();
            checkOutput("done_single", {63'd0, bus.done}, 64'd0);
        end
    endtask

    initial begin
        int n;
        logic [2:0] rop;
        logic [WIDTH-1:0] ra, rb;
        clk = 0; rst = 1; checks = 0; failures = 0;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        expHi = 0; expLo = 0;
        tick(); tick();
        rst = 0;
        tick();
        checkOutput("rst_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, bus.lo}, 64'd0);
        checkOutput("rst_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rst_done", {63'd0, bus.done}, 64'd0);

        // Directed arithmetic cases with hand-computed anchors
        applyStimulus(3'd0, -32'sd3, 32'd5);
        checkOutput("mult_hi_k", {32'd0, bus.hi}, 64'hFFFFFFFF);
        checkOutput("mult_lo_k", {32'd0, bus.lo}, 64'hFFFFFFF1);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2);
        checkOutput("multu_hi_k", {32'd0, bus.hi}, 64'h1);
        checkOutput("multu_lo_k", {32'd0, bus.lo}, 64'hFFFFFFFE);
        applyStimulus(3'd2, -32'sd7, 32'd2);
        checkOutput("div_lo_k", {32'd0, bus.lo}, 64'hFFFFFFFD);
        checkOutput("div_hi_k", {32'd0, bus.hi}, 64'hFFFFFFFF);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'd16);
        checkOutput("divu_lo_k", {32'd0, bus.lo}, 64'h0FFFFFFF);
        checkOutput("divu_hi_k", {32'd0, bus.hi}, 64'hF);
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
        checkOutput("minint_lo_k", {32'd0, bus.lo}, 64'h80000000);
        checkOutput("minint_hi_k", {32'd0, bus.hi}, 64'h0);

        // Preload then divide by zero leaves HI/LO alone
        applyStimulus(3'd4, 32'h1234, 32'd0);
        applyStimulus(3'd5, 32'h5678, 32'd0);
        applyStimulus(3'd2, 32'd99, 32'd0);
        checkOutput("dz_hi_k", {32'd0, bus.hi}, 64'h1234);
        checkOutput("dz_lo_k", {32'd0, bus.lo}, 64'h5678);

        // Randomized command stream
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 0) rb = -rb;
            applyStimulus(rop, ra, rb);
        end

        // Flush ten cycles into a divide
        bus.op = 3'd2; bus.a = $urandom; bus.b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        checkOutput("flush_pre_busy", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("flush_done", {63'd0, bus.done}, 64'd0);
        tick();
        checkOutput("flush_done2", {63'd0, bus.done}, 64'd0);
        checkOutput("flush_hi", {32'd0, bus.hi}, {32'd0, expHi});
        checkOutput("flush_lo", {32'd0, bus.lo}, {32'd0, expLo});

        // Start pulsed while busy is ignored
        bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        modelOp(3'd3, 32'd1000, 32'd7);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                bus.op = 3'd5; bus.a = 32'hDEAD; bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
        checkOutput("ign_busy_len", 64'(n), 64'(WIDTH + 1));
        checkOutput("ign_done", {63'd0, bus.done}, 64'd1);
        checkOutput("ign_lo", {32'd0, bus.lo}, 64'd142);
        checkOutput("ign_hi", {32'd0, bus.hi}, 64'd6);
        tick();

        // Start together with flush in IDLE is dropped
        bus.op = 3'd4; bus.a = 32'hCAFE; bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        checkOutput("sf_mthi_hi", {32'd0, bus.hi}, {32'd0, expHi});
        bus.op = 3'd2; bus.b = 32'd5;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        checkOutput("sf_div_busy", {63'd0, bus.busy}, 64'd0);

        // Undefined op code is ignored
        bus.op = 3'd6; bus.a = 32'hBEEF; bus.b = 32'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("undef_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("undef_hi", {32'd0, bus.hi}, {32'd0, expHi});
        checkOutput("undef_lo", {32'd0, bus.lo}, {32'd0, expLo});

        // Reset in the middle of a divide
        bus.op = 3'd3; bus.a = 32'd12345; bus.b = 32'd11; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expHi = 0; expLo = 0;
        checkOutput("mrst_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("mrst_done", {63'd0, bus.done}, 64'd0);
        checkOutput("mrst_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("mrst_lo", {32'd0, bus.lo}, 64'd0);

        // Unit still works after the reset
        applyStimulus(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
